// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Purpose  : General-purpose register file for the MIPS datapath with a
//             per-register pending-write scoreboard. NUM_RD combinational
//             read ports, one synchronous write port, optional same-cycle
//             write-to-read bypass and optional hardwired-zero register 0.
//  Ports    : clk, rst          - rising-edge clock, sync active-high reset
//             rd_addr/rd_data   - packed read addresses / read data, port k
//                                 at [k*ADDR_W +: ADDR_W] / [k*DATA_W +: DATA_W]
//             rd_busy           - per-port pending-write flag
//             we, wa, wd        - write enable / address / data (writeback)
//             bs_en, bs_addr    - busy-set strobe on issue of a producer
//             busy_any          - OR of the registered busy bits
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          wa,
  input  logic [DATA_W-1:0]          wd,
  input  logic                       bs_en,
  input  logic [ADDR_W-1:0]          bs_addr,
  output logic                       busy_any
);

  localparam int   DEPTH       = 1 << ADDR_W;
  localparam logic c_zero_en   = (ZERO_REG != 0);
  localparam logic c_bypass_en = (BYPASS != 0);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  // Writes and busy-sets aimed at the zero register are dropped here, so
  // r0 storage and its busy bit stay 0 forever after reset.
  logic w_we_eff;
  logic w_bs_eff;
  logic w_same_set;

  assign w_we_eff   = we    && !(c_zero_en && (wa == '0));
  assign w_bs_eff   = bs_en && !(c_zero_en && (bs_addr == '0));
  // A new producer issued on the very edge the old one retires: the
  // register must remain pending.
  assign w_same_set = w_bs_eff && (bs_addr == wa);

  // --------------------------------------------------------------------------
  // Scoreboard next state: clear on writeback first, then set on issue so a
  // coincident set overrides the clear.
  // --------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    if (w_we_eff) begin
      busy_d[wa] = 1'b0;
    end
    if (w_bs_eff) begin
      busy_d[bs_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (w_we_eff) begin
        regs_q[wa] <= wd;
      end
      busy_q <= busy_d;
    end
  end

  assign busy_any = |busy_q;

  // --------------------------------------------------------------------------
  // Read ports: purely combinational, each port independent.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_zero;
    logic              w_hit;

    assign w_ra   = rd_addr[k*ADDR_W +: ADDR_W];
    assign w_zero = c_zero_en && (w_ra == '0);
    // w_we_eff already excludes r0, so the bypass can never hit it.
    assign w_hit  = c_bypass_en && w_we_eff && (wa == w_ra);

    assign rd_data[k*DATA_W +: DATA_W] = w_zero ? '0 :
                                         w_hit  ? wd  :
                                                  regs_q[w_ra];

    // On a bypass hit the retiring producer is forwarded as not-busy unless
    // a new producer for the same register issues in the same cycle.
    assign rd_busy[k] = w_zero ? 1'b0       :
                        w_hit  ? w_same_set :
                                 busy_q[w_ra];
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_sb
//  Purpose  : Self-checking bench for regfile_sb (NUM_RD=3, BYPASS=1,
//             ZERO_REG=1). Expected read results are queued as stimulus is
//             applied and compared when the outputs are sampled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              we;
  logic [AW-1:0]     wa;
  logic [DW-1:0]     wd;
  logic              bs_en;
  logic [AW-1:0]     bs_addr;
  logic              busy_any;

  regfile_sb #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .NUM_RD  (NR),
    .ZERO_REG(1),
    .BYPASS  (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_busy (rd_busy),
    .we      (we),
    .wa      (wa),
    .wd      (wd),
    .bs_en   (bs_en),
    .bs_addr (bs_addr),
    .busy_any(busy_any)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expectation queue: kind 0..NR-1 = rd_data port, NR..2NR-1 = rd_busy
  // port, 2NR = busy_any.
  string       q_tag [$];
  int          q_kind[$];
  logic [31:0] q_exp [$];

  // Reference state
  logic [DW-1:0] m_regs [32];
  logic [31:0]   m_busy;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int kind, input logic [31:0] e);
    q_tag.push_back(tag);
    q_kind.push_back(kind);
    q_exp.push_back(e);
  endtask

  task automatic drain();
    logic [31:0] obs;
    while (q_kind.size() > 0) begin
      int    kd  = q_kind.pop_front();
      string tg  = q_tag.pop_front();
      logic [31:0] ex = q_exp.pop_front();
      if (kd < NR)          obs = rd_data[kd*DW +: DW];
      else if (kd < 2*NR)   obs = {31'd0, rd_busy[kd-NR]};
      else                  obs = {31'd0, busy_any};
      check_val(tg, obs, ex);
    end
  endtask

  // Registered-state update mirroring what the edge should do.
  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_busy = '0;
    end else begin
      if (we && wa != 0) begin
        m_regs[wa] = wd;
        m_busy[wa] = 1'b0;
      end
      if (bs_en && bs_addr != 0) m_busy[bs_addr] = 1'b1;
    end
  endtask

  function automatic logic [31:0] m_data(input logic [AW-1:0] a);
    if (a == 0)              return 32'd0;
    if (we && wa == a)       return wd;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] m_rbusy(input logic [AW-1:0] a);
    if (a == 0)              return 32'd0;
    if (we && wa == a)       return {31'd0, bs_en && (bs_addr == a)};
    return {31'd0, m_busy[a]};
  endfunction

  task automatic push_model(input string tag);
    for (int k = 0; k < NR; k++) begin
      push({tag, "_data"}, k, m_data(rd_addr[k*AW +: AW]));
      push({tag, "_busy"}, NR + k, m_rbusy(rd_addr[k*AW +: AW]));
    end
    push({tag, "_any"}, 2*NR, {31'd0, |m_busy});
  endtask

  // Sample at the falling edge, then advance one rising edge.
  task automatic cycle();
    @(negedge clk);
    drain();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2);
    rd_addr = {a2, a1, a0};
  endtask

  task automatic idle();
    rst = 1'b0; we = 1'b0; bs_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; bs_en = 1'b0; bs_addr = '0;
    rd_addr = '0;
    m_busy = '0;
    @(posedge clk); #1;
    cycle();
    idle();

    // Reset state
    set_rd(0, 5, 31);
    for (int k = 0; k < NR; k++) begin
      push("rst_data", k, 32'd0);
      push("rst_busy", NR + k, 32'd0);
    end
    push("rst_any", 2*NR, 32'd0);
    cycle();

    // Reset clears a written register
    we = 1'b1; wa = 5; wd = 32'hDEADBEEF;
    cycle();
    idle(); rst = 1'b1;
    cycle();
    idle(); set_rd(5, 5, 5);
    push("rst_r5", 0, 32'h0);
    push("rst_r5_busy", NR, 32'h0);
    push("rst_r5_any", 2*NR, 32'h0);
    cycle();

    // Write with same-cycle bypass, then registered value
    we = 1'b1; wa = 7; wd = 32'h12345678; set_rd(7, 0, 0);
    push("byp_r7", 0, 32'h12345678);
    cycle();
    idle();
    push("reg_r7", 0, 32'h12345678);
    cycle();

    // Zero register ignores write and busy-set
    we = 1'b1; wa = 0; wd = 32'hFFFFFFFF; bs_en = 1'b1; bs_addr = 0;
    set_rd(0, 0, 0);
    for (int k = 0; k < NR; k++) begin
      push("r0_data_w", k, 32'd0);
      push("r0_busy_w", NR + k, 32'd0);
    end
    cycle();
    idle();
    for (int k = 0; k < NR; k++) begin
      push("r0_data", k, 32'd0);
      push("r0_busy", NR + k, 32'd0);
    end
    push("r0_any", 2*NR, 32'd0);
    cycle();

    // Scoreboard lifecycle on r9
    bs_en = 1'b1; bs_addr = 9; set_rd(9, 9, 0);
    push("bs_same_cyc", NR, 32'd0);
    push("bs_same_any", 2*NR, 32'd0);
    cycle();
    idle();
    for (int c = 0; c < 3; c++) begin
      push("r9_busy", NR, 32'd1);
      push("r9_any", 2*NR, 32'd1);
      cycle();
    end
    we = 1'b1; wa = 9; wd = 32'hA5A5A5A5;
    push("wb_busy", NR, 32'd0);
    push("wb_data", 0, 32'hA5A5A5A5);
    push("wb_any", 2*NR, 32'd1);
    cycle();
    idle();
    push("post_wb_any", 2*NR, 32'd0);
    push("post_wb_data", 1, 32'hA5A5A5A5);
    cycle();

    // Simultaneous set/clear on r3
    bs_en = 1'b1; bs_addr = 3; set_rd(3, 3, 3);
    cycle();
    idle();
    we = 1'b1; wa = 3; wd = 32'h55; bs_en = 1'b1; bs_addr = 3;
    push("sc_busy_same", NR, 32'd1);
    push("sc_data_same", 0, 32'h55);
    cycle();
    idle();
    push("sc_data", 0, 32'h55);
    push("sc_busy", NR + 1, 32'd1);
    push("sc_any", 2*NR, 32'd1);
    cycle();
    we = 1'b1; wa = 3; wd = 32'h66;
    cycle();
    idle();

    // Multi-port concurrent reads
    we = 1'b1; wa = 1; wd = 32'h11;
    cycle();
    wa = 2; wd = 32'h22;
    cycle();
    idle(); set_rd(1, 1, 2);
    push("mp0", 0, 32'h11);
    push("mp1", 1, 32'h11);
    push("mp2", 2, 32'h22);
    cycle();
    bs_en = 1'b1; bs_addr = 1;
    cycle();
    idle();
    push("mp_busy0", NR, 32'd1);
    push("mp_busy1", NR + 1, 32'd1);
    push("mp_busy2", NR + 2, 32'd0);
    push("mp_any", 2*NR, 32'd1);
    cycle();
    rst = 1'b1;
    cycle();
    idle();
    push("mp_rst_busy", NR, 32'd0);
    push("mp_rst_any", 2*NR, 32'd0);
    push("mp_rst_data", 2, 32'd0);
    cycle();

    // Random traffic against the reference model
    for (int c = 0; c < 300; c++) begin
      we      = ($urandom_range(0, 99) < 50);
      wa      = AW'($urandom_range(0, 7));
      wd      = $urandom;
      bs_en   = ($urandom_range(0, 99) < 40);
      bs_addr = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 7));
      set_rd(($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 7)),
             AW'($urandom_range(0, 7)), bs_addr);
      push_model("rnd");
      cycle();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
